// File: rtl/icache_prefetch_ctrl_pkg.sv
// Shared types and constants for the sequential-stream instruction prefetcher.
// Bus command encoding, icache geometry and memory-tag space live here.
package icache_prefetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  localparam int ICACHE_IDX_BITS  = 7;
  localparam int ICACHE_TAG_BITS  = 22;
  localparam int MEM_TAG_BITS     = 4;
  localparam int NUM_MEM_TAGS     = 16;
  localparam int LINE_OFFSET_BITS = 3;

  // Clear the byte offset so every address handled is an 8-byte line address.
  function automatic logic [63:0] line_align(input logic [63:0] byte_addr);
    return byte_addr & ~64'h7;
  endfunction

endpackage

// File: rtl/icache_prefetch_ctrl_if.sv
// Imem bus between the prefetch controller (master) and the memory side (slave).
interface icache_prefetch_ctrl_if;
  import icache_prefetch_ctrl_pkg::*;

  bus_cmd_e    proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;

  modport master (
    output proc2Imem_command, proc2Imem_addr,
    input  Imem2proc_response, Imem2proc_data, Imem2proc_tag
  );

  modport slave (
    input  proc2Imem_command, proc2Imem_addr,
    output Imem2proc_response, Imem2proc_data, Imem2proc_tag
  );

endinterface

// File: rtl/icache_prefetch_ctrl_req_table.sv
// Tag-indexed store of in-flight line requests: allocate on bus accept, clear on return,
// with an address CAM for duplicate suppression and a live outstanding count.
module icache_req_table
  import icache_prefetch_ctrl_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alloc_en,
  input  logic [MEM_TAG_BITS-1:0] alloc_tag,
  input  logic [63:0]             alloc_addr,
  input  logic                    clr_en,
  input  logic [MEM_TAG_BITS-1:0] clr_tag,
  input  logic [MEM_TAG_BITS-1:0] lookup_tag,
  output logic                    lookup_valid,
  output logic [63:0]             lookup_addr,
  input  logic [63:0]             match_addr,
  output logic                    match_hit,
  output logic [MEM_TAG_BITS-1:0] outst_count
);

  logic [NUM_MEM_TAGS-1:0] valid_reg;
  logic [63:0]             addr_reg [NUM_MEM_TAGS];
  logic [NUM_MEM_TAGS-1:0] match_vec;

  // Entry 0 is never allocated (tag 0 means "no tag"), so it reads back invalid and zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
      for (int i = 0; i < NUM_MEM_TAGS; i++) begin
        addr_reg[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_MEM_TAGS; i++) begin
        if (alloc_en && (alloc_tag == MEM_TAG_BITS'(i))) begin
          valid_reg[i] <= 1'b1;
          addr_reg[i]  <= alloc_addr;
        end else if (clr_en && (clr_tag == MEM_TAG_BITS'(i))) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign match_vec[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_MEM_TAGS; gi++) begin : g_match
    assign match_vec[gi] = valid_reg[gi] && (addr_reg[gi] == match_addr);
  end

  assign match_hit    = |match_vec;
  assign lookup_valid = valid_reg[lookup_tag];
  assign lookup_addr  = addr_reg[lookup_tag];

  always_comb begin
    outst_count = '0;
    for (int i = 1; i < NUM_MEM_TAGS; i++) begin
      outst_count = outst_count + MEM_TAG_BITS'(valid_reg[i]);
    end
  end

endmodule

// File: rtl/icache_prefetch_ctrl.sv
// Sliding-window sequential prefetcher with miss bypass: issues up to PF_DEPTH lines ahead
// of the fetch line, fills returning lines into the icache and forwards a matching line to fetch.
module icache_prefetch_ctrl
  import icache_prefetch_ctrl_pkg::*;
#(
  parameter int PF_DEPTH  = 4,
  parameter int MAX_OUTST = 8,
  parameter int IDX_BITS  = ICACHE_IDX_BITS,
  parameter int TAG_BITS  = ICACHE_TAG_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall_icache,
  input  logic [63:0]               proc2Icache_addr,
  input  logic [63:0]               cachemem_data,
  input  logic                      cachemem_valid,
  icache_prefetch_ctrl_if.master    imem,
  output logic [63:0]               Icache_data_out,
  output logic                      Icache_valid_out,
  output logic [IDX_BITS-1:0]       current_index,
  output logic [TAG_BITS-1:0]       current_tag,
  output logic [IDX_BITS-1:0]       last_index,
  output logic [TAG_BITS-1:0]       last_tag,
  output logic                      data_write_enable
);

  localparam int K_W = $clog2(PF_DEPTH + 1);
  localparam logic [K_W-1:0]          K_MAX      = K_W'(PF_DEPTH);
  localparam logic [MEM_TAG_BITS-1:0] OUTST_CAP  = MEM_TAG_BITS'(MAX_OUTST);

  logic [63:0]             base_reg, base_next, base_adj;
  logic [K_W-1:0]          k_reg, k_next, k_adj;
  logic [63:0]             fl, window_end, next_addr;
  logic                    room, dup_hit, issue, accept, dup_skip;
  logic                    tbl_valid, hit_t, bypass;
  logic [63:0]             tbl_addr;
  logic [MEM_TAG_BITS-1:0] outst_count;

  assign fl         = line_align(proc2Icache_addr);
  assign window_end = base_reg + (64'(k_reg) << LINE_OFFSET_BITS);

  // Window adjust: retarget on an out-of-window fetch, slide on forward progress inside it.
  // A slide never underflows k because fl is bounded by base + k lines.
  always_comb begin
    base_adj = base_reg;
    k_adj    = k_reg;
    if (!stall_icache) begin
      if ((fl < base_reg) || (fl > window_end)) begin
        base_adj = fl;
        k_adj    = '0;
      end else begin
        base_adj = fl;
        k_adj    = K_W'(64'(k_reg) - ((fl - base_reg) >> LINE_OFFSET_BITS));
      end
    end
  end

  // The request address follows the adjusted window so a fresh miss goes out the same cycle.
  assign next_addr = base_adj + (64'(k_adj) << LINE_OFFSET_BITS);

  assign room     = !reset && !stall_icache && (k_adj < K_MAX);
  assign dup_skip = room && dup_hit;
  assign issue    = room && !dup_hit && (outst_count < OUTST_CAP);
  assign accept   = issue && (imem.Imem2proc_response != '0);

  always_comb begin
    base_next = base_adj;
    k_next    = k_adj;
    if (accept || dup_skip) begin
      k_next = k_adj + K_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_reg <= '0;
      k_reg    <= '0;
    end else begin
      base_reg <= base_next;
      k_reg    <= k_next;
    end
  end

  icache_req_table u_req_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (accept),
    .alloc_tag    (imem.Imem2proc_response),
    .alloc_addr   (next_addr),
    .clr_en       (hit_t),
    .clr_tag      (imem.Imem2proc_tag),
    .lookup_tag   (imem.Imem2proc_tag),
    .lookup_valid (tbl_valid),
    .lookup_addr  (tbl_addr),
    .match_addr   (next_addr),
    .match_hit    (dup_hit),
    .outst_count  (outst_count)
  );

  // Fill and bypass depend only on the returning tag, never on the fetch stall.
  assign hit_t  = !reset && (imem.Imem2proc_tag != '0) && tbl_valid;
  assign bypass = hit_t && (tbl_addr == fl);

  assign imem.proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
  assign imem.proc2Imem_addr    = next_addr;

  assign Icache_data_out   = bypass ? imem.Imem2proc_data : cachemem_data;
  assign Icache_valid_out  = bypass ? 1'b1 : cachemem_valid;
  assign data_write_enable = hit_t;

  assign current_index = proc2Icache_addr[LINE_OFFSET_BITS +: IDX_BITS];
  assign current_tag   = proc2Icache_addr[LINE_OFFSET_BITS + IDX_BITS +: TAG_BITS];
  assign last_index    = tbl_addr[LINE_OFFSET_BITS +: IDX_BITS];
  assign last_tag      = tbl_addr[LINE_OFFSET_BITS + IDX_BITS +: TAG_BITS];

endmodule

// File: tb/tb_icache_prefetch_ctrl.sv
// Directed bench for icache_prefetch_ctrl: issue window, returns/bypass, slide, retarget,
// retry, stall, duplicate skip and same-cycle clear/re-allocate.
module tb_icache_prefetch_ctrl;
  import icache_prefetch_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_icache;
  logic [63:0] proc2Icache_addr;
  logic [63:0] cachemem_data;
  logic        cachemem_valid;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic [6:0]  current_index, last_index;
  logic [21:0] current_tag, last_tag;
  logic        data_write_enable;

  int n_cmp = 0;
  int n_bad = 0;

  icache_prefetch_ctrl_if bus ();

  icache_prefetch_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .stall_icache      (stall_icache),
    .proc2Icache_addr  (proc2Icache_addr),
    .cachemem_data     (cachemem_data),
    .cachemem_valid    (cachemem_valid),
    .imem              (bus.master),
    .Icache_data_out   (Icache_data_out),
    .Icache_valid_out  (Icache_valid_out),
    .current_index     (current_index),
    .current_tag       (current_tag),
    .last_index        (last_index),
    .last_tag          (last_tag),
    .data_write_enable (data_write_enable)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge; checks follow at #2 (mid-cycle).
  task automatic drive(input logic [63:0] fa, input logic [3:0] resp, input logic [3:0] rtag,
                       input logic [63:0] rdata, input logic st, input logic cvalid,
                       input logic [63:0] cdata);
    proc2Icache_addr        = fa;
    bus.Imem2proc_response  = resp;
    bus.Imem2proc_tag       = rtag;
    bus.Imem2proc_data      = rdata;
    stall_icache            = st;
    cachemem_valid          = cvalid;
    cachemem_data           = cdata;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_req(input string tag, input bus_cmd_e cmd, input logic [63:0] addr);
    check_val({tag, "_cmd"}, 64'(bus.proc2Imem_command), 64'(cmd));
    if (cmd == BUS_LOAD) check_val({tag, "_addr"}, bus.proc2Imem_addr, addr);
  endtask

  initial begin
    reset = 1'b1;
    drive(64'h1000, 4'd0, 4'd1, 64'h0, 1'b0, 1'b1, 64'hAAAA);
    next_cycle();
    drive(64'h1000, 4'd0, 4'd1, 64'h0, 1'b0, 1'b1, 64'hAAAA);
    check_val("rst_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
    check_val("rst_we", 64'(data_write_enable), 64'd0);
    check_val("rst_valid", 64'(Icache_valid_out), 64'd1);
    check_val("rst_data", Icache_data_out, 64'hAAAA);
    next_cycle();
    reset = 1'b0;

    // Fresh miss at 0x1000: four accepted requests fill the window.
    drive(64'h1000, 4'd1, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk_req("req0", BUS_LOAD, 64'h1000);
    next_cycle();
    drive(64'h1000, 4'd2, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk_req("req1", BUS_LOAD, 64'h1008);
    next_cycle();
    drive(64'h1000, 4'd3, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk_req("req2", BUS_LOAD, 64'h1010);
    next_cycle();
    drive(64'h1000, 4'd4, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk_req("req3", BUS_LOAD, 64'h1018);
    next_cycle();
    drive(64'h1000, 4'd0, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk_req("full", BUS_NONE, 64'h0);
    next_cycle();

    // Tag 1 returns for the fetched line: bypass plus fill.
    drive(64'h1000, 4'd0, 4'd1, 64'hDEAD_BEEF_0000_1000, 1'b0, 1'b0, 64'h0);
    check_val("byp_valid", 64'(Icache_valid_out), 64'd1);
    check_val("byp_data", Icache_data_out, 64'hDEAD_BEEF_0000_1000);
    check_val("byp_we", 64'(data_write_enable), 64'd1);
    check_val("byp_lidx", 64'(last_index), 64'h00);
    check_val("byp_ltag", 64'(last_tag), 64'h4);
    chk_req("byp", BUS_NONE, 64'h0);
    next_cycle();
    drive(64'h1000, 4'd0, 4'd1, 64'h1234, 1'b0, 1'b0, 64'h0);
    check_val("clr_we", 64'(data_write_enable), 64'd0);
    check_val("clr_valid", 64'(Icache_valid_out), 64'd0);
    next_cycle();

    // Slide to 0x1010 (k 4->2), then the bus rejects for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(64'h1010, 4'd0, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
      chk_req($sformatf("retry%0d", i), BUS_LOAD, 64'h1020);
      next_cycle();
    end
    drive(64'h1014, 4'd0, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    check_val("cur_idx", 64'(current_index), 64'h02);
    check_val("cur_tag", 64'(current_tag), 64'h4);
    chk_req("sub_line", BUS_LOAD, 64'h1020);
    next_cycle();

    // Stall blocks issue but tag 2 (0x1008) still fills, no bypass.
    drive(64'h1010, 4'd9, 4'd2, 64'h2222, 1'b1, 1'b1, 64'h5555);
    chk_req("stall", BUS_NONE, 64'h0);
    check_val("stall_we", 64'(data_write_enable), 64'd1);
    check_val("stall_lidx", 64'(last_index), 64'h01);
    check_val("stall_data", Icache_data_out, 64'h5555);
    next_cycle();

    // Jump to 0x8000: same-cycle request; late tag 3 (0x1010) fills without bypass.
    drive(64'h8000, 4'd6, 4'd3, 64'h3333, 1'b0, 1'b0, 64'h0);
    chk_req("jump", BUS_LOAD, 64'h8000);
    check_val("late_we", 64'(data_write_enable), 64'd1);
    check_val("late_valid", 64'(Icache_valid_out), 64'd0);
    check_val("late_lidx", 64'(last_index), 64'h02);
    next_cycle();
    drive(64'h8000, 4'd0, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk_req("jump_next", BUS_LOAD, 64'h8008);
    next_cycle();

    // Retarget onto in-flight 0x1018 (tag 4): skip, then 0x1020.
    drive(64'h1018, 4'd0, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk_req("dup", BUS_NONE, 64'h0);
    next_cycle();
    drive(64'h1018, 4'd7, 4'd0, 64'h0, 1'b0, 1'b0, 64'h0);
    chk_req("after_dup", BUS_LOAD, 64'h1020);
    next_cycle();
    drive(64'h1018, 4'd0, 4'd4, 64'h4444, 1'b0, 1'b0, 64'h0);
    check_val("byp2_valid", 64'(Icache_valid_out), 64'd1);
    check_val("byp2_data", Icache_data_out, 64'h4444);
    chk_req("byp2", BUS_LOAD, 64'h1028);
    next_cycle();

    // Tag 7 returns (0x1020) while being re-allocated for 0x1028: allocation wins.
    drive(64'h1018, 4'd7, 4'd7, 64'h7777, 1'b0, 1'b0, 64'h0);
    chk_req("realloc", BUS_LOAD, 64'h1028);
    check_val("realloc_lidx", 64'(last_index), 64'h04);
    check_val("realloc_valid", 64'(Icache_valid_out), 64'd0);
    next_cycle();
    drive(64'h1018, 4'd0, 4'd7, 64'h8888, 1'b0, 1'b0, 64'h0);
    check_val("realloc_we", 64'(data_write_enable), 64'd1);
    check_val("realloc_lidx2", 64'(last_index), 64'h05);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
